// File: rtl/seg_display_scanner_pkg.sv
// seg_pkg: character codes and logical (active-high, gfedcba) segment patterns
// shared by the seven-segment scanner and its character ROM.
package seg_pkg;

    localparam logic [3:0] CH_A     = 4'd0;
    localparam logic [3:0] CH_B     = 4'd1;
    localparam logic [3:0] CH_D     = 4'd2;
    localparam logic [3:0] CH_E     = 4'd3;
    localparam logic [3:0] CH_ML    = 4'd4;
    localparam logic [3:0] CH_MR    = 4'd5;
    localparam logic [3:0] CH_S     = 4'd8;
    localparam logic [3:0] CH_U     = 4'd9;
    localparam logic [3:0] CH_V     = 4'd10;
    localparam logic [3:0] CH_I     = 4'd12;
    localparam logic [3:0] CH_BLANK = 4'd15;

    localparam logic [6:0] SEG_A     = 7'h77;
    localparam logic [6:0] SEG_B     = 7'h7C;
    localparam logic [6:0] SEG_D     = 7'h5E;
    localparam logic [6:0] SEG_E     = 7'h79;
    localparam logic [6:0] SEG_ML    = 7'h37;
    localparam logic [6:0] SEG_MR    = 7'h07;
    localparam logic [6:0] SEG_S     = 7'h6D;
    localparam logic [6:0] SEG_U     = 7'h3E;
    localparam logic [6:0] SEG_V     = 7'h1C;
    localparam logic [6:0] SEG_I     = 7'h06;
    localparam logic [6:0] SEG_BLANK = 7'h00;

endpackage

// File: rtl/seg_display_scanner_if.sv
// seg_display_scanner_if: valid/ack character-word handshake between the
// op-code decoder (master) and the display scanner (slave).
interface seg_display_scanner_if;

    logic [15:0] char_word;
    logic        word_valid;
    logic        word_ack;

    modport master (output char_word, output word_valid, input word_ack);
    modport slave  (input char_word, input word_valid, output word_ack);

endinterface

// File: rtl/seg_display_scanner_char_rom.sv
// seg_char_rom: character code to logical segment pattern; unknown codes are blank.
module seg_char_rom
    import seg_pkg::*;
(
    input  logic [3:0] code,
    output logic [6:0] pattern
);

    always_comb begin
        pattern = SEG_BLANK;
        case (code)
            CH_A:    pattern = SEG_A;
            CH_B:    pattern = SEG_B;
            CH_D:    pattern = SEG_D;
            CH_E:    pattern = SEG_E;
            CH_ML:   pattern = SEG_ML;
            CH_MR:   pattern = SEG_MR;
            CH_S:    pattern = SEG_S;
            CH_U:    pattern = SEG_U;
            CH_V:    pattern = SEG_V;
            CH_I:    pattern = SEG_I;
            default: pattern = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg_display_scanner.sv
// seg_display_scanner: 4-digit time-multiplexed seven-segment driver with
// frame-aligned word capture; optional blinking when SEG_BLINK_EN is defined.
module seg_display_scanner
    import seg_pkg::*;
#(
    parameter int unsigned REFRESH_DIV    = 50000,
    parameter bit          SEG_ACTIVE_LOW = 1'b1,
    parameter bit          AN_ACTIVE_LOW  = 1'b1
`ifdef SEG_BLINK_EN
    ,
    parameter int unsigned BLINK_FRAMES   = 64
`endif
)(
    input  logic                  clk,
    input  logic                  rst,
    seg_display_scanner_if.slave  word,
    output logic                  frame_tick,
    output logic [6:0]            seg,
    output logic [3:0]            an
`ifdef SEG_BLINK_EN
    ,
    input  logic                  blink
`endif
);

    localparam int DW = $clog2(REFRESH_DIV);

    logic [DW-1:0] div_cnt;
    logic [1:0]    digit;
    logic [15:0]   shadow;
    logic          wrap;
    logic          boundary;
    logic [3:0]    code;
    logic [6:0]    pattern;
    logic [3:0]    an_log;
    logic          an_off;

    assign wrap          = div_cnt == DW'(REFRESH_DIV - 1);
    assign boundary      = wrap && digit == 2'd3;
    assign frame_tick    = boundary;
    assign word.word_ack = boundary && word.word_valid;
    assign code          = shadow[{digit, 2'b00} +: 4];
    assign an_log        = 4'b0001 << digit;

    seg_char_rom u_rom (
        .code    (code),
        .pattern (pattern)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
            digit   <= 2'd0;
            shadow  <= 16'hFFFF;
            seg     <= {7{SEG_ACTIVE_LOW}};
            an      <= {4{AN_ACTIVE_LOW}};
        end else begin
            div_cnt <= wrap ? '0 : div_cnt + 1'b1;
            digit   <= digit + {1'b0, wrap};
            if (word.word_ack)
                shadow <= word.char_word;
            seg     <= pattern ^ {7{SEG_ACTIVE_LOW}};
            an      <= (an_off ? 4'h0 : an_log) ^ {4{AN_ACTIVE_LOW}};
        end
    end

`ifdef SEG_BLINK_EN
    localparam int FW = $clog2(BLINK_FRAMES) + 1;

    logic [FW-1:0] frame_cnt;
    logic          blink_phase;

    // blink_phase flips once every BLINK_FRAMES completed frames
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (boundary) begin
            if (frame_cnt == FW'(BLINK_FRAMES - 1)) begin
                frame_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                frame_cnt   <= frame_cnt + 1'b1;
            end
        end
    end

    assign an_off = blink && blink_phase;
`else
    assign an_off = 1'b0;
`endif

endmodule
